branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- ID-stage counterpart to the fetch-side BTB predictor.
- Holds the prediction metadata captured at fetch and resolves the actual branch/JAL outcome in ID.
- Detects mispredictions, drives the fetch redirect and the IF/ID flush, and emits the registered BTB update (update_en, branch_taken, resolved_pc, resolved_target, resolved_state).
- Keeps saturating performance counters.

Parameters:
- CNT_W, 16, width of the perf_branches and perf_mispredicts counters.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- if_valid  input  1  fetch stage holds a valid instruction
- if_pc  input  32  PC of the fetched instruction
- if_pred_taken  input  1  predictor prediction bit for if_pc
- if_pred_target  input  32  predicted target for if_pc
- if_pred_state  input  2  predictor FSM state for if_pc
- stall  input  1  hazard stall; IF/ID is held and ID does not advance
- id_is_branch  input  1  ID instruction is a conditional branch
- id_is_jal  input  1  ID instruction is JAL
- id_funct3  input  3  branch funct3
- id_rs1_val  input  32  forwarded rs1 value
- id_rs2_val  input  32  forwarded rs2 value
- id_imm  input  32  sign-extended B/J immediate
- update_en  output  1  BTB write strobe, registered
- branch_taken  output  1  actual outcome, registered
- resolved_pc  output  32  PC of the resolved instruction, registered
- resolved_target  output  32  computed target, registered
- resolved_state  output  2  FSM state carried from fetch, registered
- redirect_valid  output  1  misprediction detected this cycle, combinational
- redirect_pc  output  32  correct next PC, combinational
- flush_ifid  output  1  squash the fetch-stage instruction, equal to redirect_valid
- perf_branches  output  CNT_W  count of resolved control-transfer instructions
- perf_mispredicts  output  CNT_W  count of mispredictions

Behaviour:
- Reset: rst is asynchronous, active-high. Clock is clk, rising edge.
  - All registered outputs, both counters and the metadata register clear to 0.
  - A pending update is dropped.
- Metadata register: {meta_valid, meta_pc, meta_taken, meta_target, meta_state}.
  - stall=1: hold.
  - stall=0 and redirect_valid=1: meta_valid <= 0; flush wins over a simultaneous if_valid.
  - Otherwise: load the if_* inputs, with meta_valid <= if_valid.
- Resolve condition: resolve = meta_valid & ~stall & (id_is_jal | (id_is_branch & legal funct3)).
  - A held instruction resolves exactly once, in the cycle stall drops.
- Condition evaluation by funct3:
  - 000 BEQ, 001 BNE
  - 100 BLT, 101 BGE (signed compare)
  - 110 BLTU, 111 BGEU (unsigned compare)
  - 010 and 011 are illegal: no resolve, no update, no count.
  - JAL is always taken.
- Target: tgt = meta_pc + id_imm, modulo 2^32 with silent wrap; fallthrough = meta_pc + 4, also wrapping.
- Misprediction: mis = resolve & ((taken != meta_taken) | (taken & meta_taken & tgt != meta_target)).
- Redirect:
  - redirect_valid = mis.
  - redirect_pc = taken ? tgt : fallthrough.
  - When mis=0, redirect_pc is don't-care and is driven 0.
- BTB update: on resolve, on the next clock:
  - update_en <= 1, branch_taken <= taken, resolved_pc <= meta_pc, resolved_target <= tgt, resolved_state <= meta_state.
  - Otherwise update_en <= 0 and the data outputs hold their last values.
  - One-cycle update latency is accepted: a fetch of the same PC in the update cycle reads the stale entry.
- Counters:
  - perf_branches increments on resolve; perf_mispredicts increments on mis.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Non-control instructions in ID: no resolve, no redirect, update_en=0.

Decomposition:
- Package bp_pkg:
  - state_t enum (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11).
  - funct3 localparams F3_BEQ..F3_BGEU.
  - XLEN=32.
  - Shared with the predictor.
- Sub-module branch_compare: combinational, takes funct3, rs1, rs2; outputs taken and legal.

Test Plan:
- Correct not-taken: meta pc=0x100, pred_taken=0; BEQ rs1=1, rs2=2.
  -> redirect_valid=0; next cycle update_en=1, branch_taken=0, resolved_pc=0x100; perf_branches=1.
- Mispredicted taken: pc=0x200, pred_taken=0; BNE rs1=1, rs2=2, imm=0x40.
  -> redirect_valid=1, redirect_pc=0x240, flush_ifid=1; meta_valid cleared next cycle even with if_valid=1; perf_mispredicts=1.
- Target mismatch: pc=0x300, pred_taken=1, pred_target=0x310; JAL imm=0x20.
  -> redirect_pc=0x320; update resolved_target=0x320, resolved_state equals carried if_pred_state.
- Signed vs unsigned compare: rs1=0xFFFFFFFF, rs2=1.
  -> BLT taken, BLTU not taken.
  -> funct3=010 gives update_en=0 and no count.
- Stall: branch held with stall=1 for 3 cycles, then released.
  -> exactly one update_en pulse and perf_branches increments by 1; no redirect while stalled.
- Reset and wrap:
  - Assert rst mid-resolve -> update_en=0, counters=0 immediately.
  - Force both counters to 0xFFFF and resolve a mispredicting branch -> both stay 0xFFFF.
  - pc=0xFFFFFFFC, not taken, mispredicted taken -> redirect_pc=0x0.

Source files
------------

// File: rtl/bp_pkg.sv
// Branch prediction shared definitions.
// Used by the fetch-side BTB predictor and the ID-stage branch_resolve_unit:
// XLEN, the 2-bit predictor FSM encoding, branch funct3 codes and the
// metadata record carried from fetch into ID.
package bp_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Prediction captured at fetch, travelling alongside the instruction in IF/ID.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
    state_t          state;
  } meta_t;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluator.
// Ports:
//   funct3 - branch funct3 from the ID instruction
//   rs1    - forwarded rs1 value
//   rs2    - forwarded rs2 value
//   taken  - condition holds (0 when funct3 is illegal)
//   legal  - funct3 names a real conditional branch (010/011 are not)
module branch_compare
  import bp_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            legal
);

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution.
// Holds the fetch-time prediction for the instruction in ID, evaluates the
// real branch/JAL outcome, raises a redirect + IF/ID flush on misprediction,
// emits a registered BTB update and keeps saturating perf counters.
// Ports:
//   clk, rst                        - clock, async active-high reset
//   if_valid/if_pc/if_pred_*        - fetch instruction and its prediction
//   stall                           - hold IF/ID, ID does not advance
//   id_is_branch/id_is_jal/id_funct3/id_rs1_val/id_rs2_val/id_imm - ID decode
//   update_en, branch_taken, resolved_pc, resolved_target, resolved_state
//                                   - registered BTB update
//   redirect_valid, redirect_pc     - combinational fetch redirect
//   flush_ifid                      - squash fetch-stage instruction
//   perf_branches, perf_mispredicts - saturating counters
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             if_pred_taken,
  input  logic [XLEN-1:0]  if_pred_target,
  input  logic [1:0]       if_pred_state,
  input  logic             stall,
  input  logic             id_is_branch,
  input  logic             id_is_jal,
  input  logic [2:0]       id_funct3,
  input  logic [XLEN-1:0]  id_rs1_val,
  input  logic [XLEN-1:0]  id_rs2_val,
  input  logic [XLEN-1:0]  id_imm,
  output logic             update_en,
  output logic             branch_taken,
  output logic [XLEN-1:0]  resolved_pc,
  output logic [XLEN-1:0]  resolved_target,
  output logic [1:0]       resolved_state,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);

  meta_t           meta;
  logic            cmp_taken, cmp_legal;
  logic            resolve, taken, mis;
  logic [XLEN-1:0] tgt, fall;

  branch_compare u_cmp (
    .funct3 (id_funct3),
    .rs1    (id_rs1_val),
    .rs2    (id_rs2_val),
    .taken  (cmp_taken),
    .legal  (cmp_legal)
  );

  // Gating on ~stall makes a held instruction resolve only in the release cycle.
  assign resolve = meta.valid & ~stall & (id_is_jal | (id_is_branch & cmp_legal));
  assign taken   = id_is_jal | cmp_taken;
  assign tgt     = meta.pc + id_imm;
  assign fall    = meta.pc + XLEN'(4);
  assign mis     = resolve & ((taken != meta.taken) |
                              (taken & meta.taken & (tgt != meta.target)));

  assign redirect_valid = mis;
  assign redirect_pc    = mis ? (taken ? tgt : fall) : '0;
  assign flush_ifid     = mis;

  // Flush takes priority over a fetch arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
    end else if (!stall) begin
      if (mis) meta.valid <= 1'b0;
      else     meta <= '{valid:  if_valid,
                         pc:     if_pc,
                         taken:  if_pred_taken,
                         target: if_pred_target,
                         state:  state_t'(if_pred_state)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_en       <= 1'b0;
      branch_taken    <= 1'b0;
      resolved_pc     <= '0;
      resolved_target <= '0;
      resolved_state  <= '0;
    end else begin
      update_en <= resolve;
      if (resolve) begin
        branch_taken    <= taken;
        resolved_pc     <= meta.pc;
        resolved_target <= tgt;
        resolved_state  <= meta.state;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (resolve && perf_branches != '1)    perf_branches    <= perf_branches + 1'b1;
      if (mis     && perf_mispredicts != '1) perf_mispredicts <= perf_mispredicts + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a vector table of single
// fetch->resolve transactions plus hand sequences for flush priority,
// stall release, async reset and counter saturation. A second instance
// with CNT_W=3 shares all stimulus to exercise saturation cheaply.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_pred_taken, stall, id_is_branch, id_is_jal;
  logic [31:0] if_pc, if_pred_target, id_rs1_val, id_rs2_val, id_imm;
  logic [1:0]  if_pred_state;
  logic [2:0]  id_funct3;

  logic        update_en, branch_taken, redirect_valid, flush_ifid;
  logic [31:0] resolved_pc, resolved_target, redirect_pc;
  logic [1:0]  resolved_state;
  logic [15:0] perf_branches, perf_mispredicts;

  logic        s_update_en, s_branch_taken, s_redirect_valid, s_flush_ifid;
  logic [31:0] s_resolved_pc, s_resolved_target, s_redirect_pc;
  logic [1:0]  s_resolved_state;
  logic [2:0]  s_perf_branches, s_perf_mispredicts;

  always #5 clk = ~clk;

  branch_resolve_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .if_pred_state(if_pred_state), .stall(stall), .id_is_branch(id_is_branch),
    .id_is_jal(id_is_jal), .id_funct3(id_funct3), .id_rs1_val(id_rs1_val),
    .id_rs2_val(id_rs2_val), .id_imm(id_imm), .update_en(update_en),
    .branch_taken(branch_taken), .resolved_pc(resolved_pc),
    .resolved_target(resolved_target), .resolved_state(resolved_state),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_ifid(flush_ifid), .perf_branches(perf_branches),
    .perf_mispredicts(perf_mispredicts)
  );

  branch_resolve_unit #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .if_pred_state(if_pred_state), .stall(stall), .id_is_branch(id_is_branch),
    .id_is_jal(id_is_jal), .id_funct3(id_funct3), .id_rs1_val(id_rs1_val),
    .id_rs2_val(id_rs2_val), .id_imm(id_imm), .update_en(s_update_en),
    .branch_taken(s_branch_taken), .resolved_pc(s_resolved_pc),
    .resolved_target(s_resolved_target), .resolved_state(s_resolved_state),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .flush_ifid(s_flush_ifid), .perf_branches(s_perf_branches),
    .perf_mispredicts(s_perf_mispredicts)
  );

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
    logic [1:0]  st;
    logic        br;
    logic        jal;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_upd;
    logic        e_taken;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vt [11];
  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat7(input int x);
    return (x > 7) ? 7 : x;
  endfunction

  task automatic chk_cnt(input string tag);
    chk({tag, " perf_branches"},        64'(perf_branches),      64'(exp_br));
    chk({tag, " perf_mispredicts"},     64'(perf_mispredicts),   64'(exp_mis));
    chk({tag, " sat perf_branches"},    64'(s_perf_branches),    64'(sat7(exp_br)));
    chk({tag, " sat perf_mispredicts"}, 64'(s_perf_mispredicts), 64'(sat7(exp_mis)));
  endtask

  task automatic id_idle();
    id_is_branch = 1'b0; id_is_jal = 1'b0; id_funct3 = 3'b000;
    id_rs1_val = '0; id_rs2_val = '0; id_imm = '0;
  endtask

  // One cycle presenting a fetch with no control instruction in ID.
  task automatic fetch(input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                       input logic [1:0] st);
    @(negedge clk);
    stall = 1'b0; if_valid = 1'b1; if_pc = pc; if_pred_taken = pt;
    if_pred_target = ptg; if_pred_state = st;
    id_idle();
  endtask

  task automatic drive_id(input logic br, input logic jal, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm);
    id_is_branch = br; id_is_jal = jal; id_funct3 = f3;
    id_rs1_val = a; id_rs2_val = b; id_imm = imm;
  endtask

  initial begin
    // pc, pt, ptg, st, br, jal, f3, rs1, rs2, imm, e_redir, e_rpc, e_upd, e_taken, e_tgt
    vt[0]  = '{32'h100, 0, 0, 1, 1, 0, 3'b000, 1, 2, 32'h10, 0, 0, 1, 0, 32'h110};
    vt[1]  = '{32'h200, 0, 0, 0, 1, 0, 3'b001, 1, 2, 32'h40, 1, 32'h240, 1, 1, 32'h240};
    vt[2]  = '{32'h300, 1, 32'h310, 3, 0, 1, 3'b000, 0, 0, 32'h20, 1, 32'h320, 1, 1, 32'h320};
    vt[3]  = '{32'h400, 1, 32'h3F0, 2, 1, 0, 3'b100, 32'hFFFFFFFF, 1, 32'hFFFFFFF0, 0, 0, 1, 1, 32'h3F0};
    vt[4]  = '{32'h500, 1, 32'h520, 2, 1, 0, 3'b110, 32'hFFFFFFFF, 1, 32'h20, 1, 32'h504, 1, 0, 32'h520};
    vt[5]  = '{32'h600, 0, 0, 0, 1, 0, 3'b010, 1, 1, 32'h8, 0, 0, 0, 0, 0};
    vt[6]  = '{32'hFFFFFFFC, 1, 32'h8, 3, 1, 0, 3'b101, 1, 5, 32'hC, 1, 32'h0, 1, 0, 32'h8};
    vt[7]  = '{32'h700, 1, 32'h680, 1, 1, 0, 3'b111, 5, 5, 32'hFFFFFF80, 0, 0, 1, 1, 32'h680};
    vt[8]  = '{32'h800, 1, 32'h900, 3, 1, 0, 3'b000, 7, 7, 32'h80, 1, 32'h880, 1, 1, 32'h880};
    vt[9]  = '{32'h900, 1, 32'h904, 0, 0, 0, 3'b000, 0, 0, 32'h4, 0, 0, 0, 0, 0};
    vt[10] = '{32'hA00, 0, 0, 1, 1, 0, 3'b101, 32'h80000000, 0, 32'h4, 0, 0, 1, 0, 32'hA04};

    rst = 1'b1; stall = 1'b0; if_valid = 1'b0; if_pc = '0; if_pred_taken = 1'b0;
    if_pred_target = '0; if_pred_state = '0;
    id_idle();
    #3;
    chk("reset update_en", 64'(update_en), 0);
    chk("reset branch_taken", 64'(branch_taken), 0);
    chk("reset resolved_pc", 64'(resolved_pc), 0);
    chk("reset resolved_target", 64'(resolved_target), 0);
    chk("reset resolved_state", 64'(resolved_state), 0);
    chk("reset redirect_valid", 64'(redirect_valid), 0);
    chk_cnt("reset");
    @(negedge clk); rst = 1'b0;

    // Vector table: fetch cycle, then resolve cycle, then registered update.
    for (int i = 0; i < 11; i++) begin
      fetch(vt[i].pc, vt[i].pt, vt[i].ptg, vt[i].st);
      @(negedge clk);
      if_valid = 1'b0;
      drive_id(vt[i].br, vt[i].jal, vt[i].f3, vt[i].rs1, vt[i].rs2, vt[i].imm);
      #1;
      chk($sformatf("v%0d redirect_valid", i), 64'(redirect_valid), 64'(vt[i].e_redir));
      chk($sformatf("v%0d flush_ifid", i), 64'(flush_ifid), 64'(vt[i].e_redir));
      chk($sformatf("v%0d redirect_pc", i), 64'(redirect_pc), 64'(vt[i].e_rpc));
      @(posedge clk); #1;
      chk($sformatf("v%0d update_en", i), 64'(update_en), 64'(vt[i].e_upd));
      if (vt[i].e_upd) begin
        chk($sformatf("v%0d branch_taken", i), 64'(branch_taken), 64'(vt[i].e_taken));
        chk($sformatf("v%0d resolved_pc", i), 64'(resolved_pc), 64'(vt[i].pc));
        chk($sformatf("v%0d resolved_target", i), 64'(resolved_target), 64'(vt[i].e_tgt));
        chk($sformatf("v%0d resolved_state", i), 64'(resolved_state), 64'(vt[i].st));
      end
      exp_br  += int'(vt[i].e_upd);
      exp_mis += int'(vt[i].e_redir);
      chk_cnt($sformatf("v%0d", i));
    end

    // Flush beats a fetch arriving in the mispredict cycle.
    fetch(32'h200, 1'b0, 32'h0, 2'd1);
    @(negedge clk);
    if_valid = 1'b1; if_pc = 32'h204; if_pred_taken = 1'b0;
    drive_id(1'b1, 1'b0, 3'b001, 1, 2, 32'h40);
    #1;
    chk("flush redirect_valid", 64'(redirect_valid), 1);
    chk("flush redirect_pc", 64'(redirect_pc), 64'h240);
    @(posedge clk); #1;
    exp_br++; exp_mis++;
    chk("flush update_en", 64'(update_en), 1);
    @(negedge clk);
    if_valid = 1'b0;
    drive_id(1'b0, 1'b1, 3'b000, 0, 0, 32'h100);
    #1;
    chk("flushed meta no redirect", 64'(redirect_valid), 0);
    @(posedge clk); #1;
    chk("flushed meta no update", 64'(update_en), 0);
    chk_cnt("flush");

    // Stall for three cycles, then release: exactly one resolve.
    fetch(32'hB00, 1'b0, 32'h0, 2'd1);
    @(negedge clk);
    stall = 1'b1; if_valid = 1'b1; if_pc = 32'hB04;
    drive_id(1'b1, 1'b0, 3'b000, 1, 1, 32'h8);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d redirect_valid", c), 64'(redirect_valid), 0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d update_en", c), 64'(update_en), 0);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    chk("release redirect_valid", 64'(redirect_valid), 1);
    chk("release redirect_pc", 64'(redirect_pc), 64'hB08);
    @(posedge clk); #1;
    exp_br++; exp_mis++;
    chk("release update_en", 64'(update_en), 1);
    chk("release resolved_pc", 64'(resolved_pc), 64'hB00);
    chk("release resolved_target", 64'(resolved_target), 64'hB08);
    @(negedge clk);
    if_valid = 1'b0; id_idle();
    @(posedge clk); #1;
    chk("post-release update_en", 64'(update_en), 0);
    chk_cnt("stall");

    // Async reset right after an update was captured.
    fetch(32'hD00, 1'b0, 32'h0, 2'd2);
    @(negedge clk);
    if_valid = 1'b0;
    drive_id(1'b1, 1'b0, 3'b000, 1, 2, 32'h10);
    @(posedge clk); #1;
    chk("pre-reset update_en", 64'(update_en), 1);
    #1 rst = 1'b1;
    #1;
    exp_br = 0; exp_mis = 0;
    chk("async reset update_en", 64'(update_en), 0);
    chk("async reset resolved_pc", 64'(resolved_pc), 0);
    chk_cnt("async reset");
    @(negedge clk); rst = 1'b0; id_idle();

    // Nine mispredicting JALs: wide counters reach 9, narrow ones pin at 7.
    for (int k = 0; k < 9; k++) begin
      fetch(32'hC00, 1'b0, 32'h0, 2'd0);
      @(negedge clk);
      if_valid = 1'b0;
      drive_id(1'b0, 1'b1, 3'b000, 0, 0, 32'h8);
      #1;
      chk($sformatf("sat%0d redirect_pc", k), 64'(redirect_pc), 64'hC08);
      @(posedge clk); #1;
      exp_br++; exp_mis++;
    end
    chk_cnt("saturate");
    chk("sat branches pinned", 64'(s_perf_branches), 64'h7);
    chk("sat mispredicts pinned", 64'(s_perf_mispredicts), 64'h7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
